// File: rtl/fetch_pkg.sv
// Shared constants and the buffered-instruction record for the fetch unit.
package fetch_pkg;

  localparam int          FETCH_ADDR_W   = 32;
  localparam int          FETCH_DATA_W   = 32;
  localparam int          FETCH_DEPTH    = 2;
  localparam int          FETCH_PC_INCR  = 1;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// PC loop, instruction-memory and decode-side signals of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc_next;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, inst_ready,
    output pc_next, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, inst_ready,
    input  pc_next, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/fetch_protocol_chk.sv
// Flags a memory response that arrives while no read is outstanding.
module fetch_protocol_chk (
  input logic i_clock,
  input logic i_reset,
  input logic i_rsp_valid,
  input logic i_inflight_zero
);

  a_rsp_has_request: assert property (
    @(posedge i_clock) disable iff (i_reset) !(i_rsp_valid && i_inflight_zero)
  );

endmodule

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; a pop on a full FIFO frees room
// for a push in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == CNT_W'(0));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      else           r_wr_ptr <= r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      else           r_rd_ptr <= r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge i_clock) begin
    if (w_do_push && !i_flush && !i_reset) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues in-order imem reads from the current PC, computes the
// next PC, and buffers {pc, inst} toward decode with redirect flushing.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = FETCH_ADDR_W,
  parameter int              DATA_W   = FETCH_DATA_W,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter int              PC_INCR  = FETCH_PC_INCR,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input logic                i_clock,
  input logic                i_reset,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  w_tag_count;
  logic [CNT_W-1:0]  w_out_count;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              w_tag_full, w_tag_empty;
  logic              w_out_full, w_out_empty;
  logic [ADDR_W-1:0] w_tag_head;
  fetch_entry_t      w_out_din;
  fetch_entry_t      w_out_head;
  logic [CNT_W:0]    w_inflight;
  logic [CNT_W:0]    w_occupancy;
  logic              w_req_valid, w_fire;
  logic              w_rsp_live, w_rsp_drop, w_rsp_keep;
  logic              w_out_push, w_out_pop;
  logic [ADDR_W-1:0] w_pc_next;

  // Reads awaiting discard still hold a slot, so a redirect cannot overbook the buffer.
  assign w_inflight  = {1'b0, w_tag_count} + {1'b0, r_drop_cnt};
  assign w_occupancy = w_inflight + {1'b0, w_out_count};
  assign w_req_valid = !i_reset && !bus.redirect_valid && (w_occupancy < (CNT_W+1)'(DEPTH));
  assign w_fire      = w_req_valid && bus.imem_req_ready;

  assign w_rsp_live  = bus.imem_rsp_valid && !i_reset && !bus.redirect_valid;
  assign w_rsp_drop  = w_rsp_live && (r_drop_cnt != CNT_W'(0));
  assign w_rsp_keep  = w_rsp_live && (r_drop_cnt == CNT_W'(0)) && !w_tag_empty;
  assign w_out_pop   = !w_out_empty && bus.inst_ready;
  assign w_out_push  = w_rsp_keep && (!w_out_full || w_out_pop);

  assign w_out_din.pc   = w_tag_head;
  assign w_out_din.inst = bus.imem_rsp_data;

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_fire && !w_tag_full),
    .i_din   (bus.pc_in),
    .i_pop   (w_rsp_keep),
    .i_flush (bus.redirect_valid),
    .o_dout  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_out_push),
    .i_din   (w_out_din),
    .i_pop   (w_out_pop),
    .i_flush (bus.redirect_valid),
    .o_dout  (w_out_head),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_count)
  );

  // Count of outstanding reads whose responses must be discarded after a redirect.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      if (bus.imem_rsp_valid && (w_inflight != (CNT_W+1)'(0)))
        r_drop_cnt <= w_inflight[CNT_W-1:0] - CNT_W'(1);
      else
        r_drop_cnt <= w_inflight[CNT_W-1:0];
    end else if (w_rsp_drop) begin
      r_drop_cnt <= r_drop_cnt - CNT_W'(1);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  // Next-PC select; the PC register latches this every clock, so holding pc_in stalls.
  always_comb begin
    w_pc_next = bus.pc_in;
    if (i_reset)                 w_pc_next = RESET_PC;
    else if (bus.redirect_valid) w_pc_next = bus.redirect_pc;
    else if (w_fire)             w_pc_next = bus.pc_in + ADDR_W'(PC_INCR);
    else                         w_pc_next = bus.pc_in;
  end

  assign bus.pc_next        = w_pc_next;
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.inst_valid     = !w_out_empty;
  assign bus.inst_pc        = w_out_head.pc;
  assign bus.inst_data      = w_out_head.inst;

  fetch_protocol_chk u_chk (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_rsp_valid     (bus.imem_rsp_valid),
    .i_inflight_zero (w_inflight == (CNT_W+1)'(0))
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Closed-loop bench: PC register + latency-configurable memory around the fetch unit,
// checked every cycle against a queue-based model of requests and buffered instructions.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] pc;
    logic [31:0] rpc;
    bit          rdy;
    logic [31:0] exp_next;
    bit          exp_rv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_fire = 0;
  mreq_t       mem_q[$];
  inst_t       buf_q[$];
  logic [31:0] deliv_q[$];
  vec_t        tbl[6];

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int seq_bad();
    int b = 0;
    for (int i = 1; i < deliv_q.size(); i++)
      if (deliv_q[i] !== deliv_q[i-1] + 32'd1) b++;
    return b;
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance PC, memory and model.
  task automatic step(input bit rst_i, input bit redir_i, input logic [31:0] rpc,
                      input bit rreq_i, input bit irdy_i,
                      output logic [31:0] o_next, output bit o_rv);
    bit          rsp, exp_rv, fire, cons;
    logic [31:0] exp_next, pc_now;
    mreq_t       m;
    rsp = !rst_i && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rst = rst_i;
    bus.redirect_valid = redir_i;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rreq_i;
    bus.inst_ready     = irdy_i;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? data_of(mem_q[0].addr) : $urandom();
    #1;
    pc_now   = bus.pc_in;
    exp_rv   = !rst_i && !redir_i && (mem_q.size() + buf_q.size() < DEPTH);
    fire     = exp_rv && rreq_i;
    exp_next = rst_i ? RESET_PC : (redir_i ? rpc : (fire ? pc_now + 32'd1 : pc_now));
    chk("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, pc_now);
    chk("pc_next", bus.pc_next, exp_next);
    chk("inst_valid", bus.inst_valid, buf_q.size() > 0);
    if (buf_q.size() > 0) begin
      chk("inst_pc", bus.inst_pc, buf_q[0].pc);
      chk("inst_data", bus.inst_data, buf_q[0].data);
    end
    cons = (buf_q.size() > 0) && irdy_i;
    if (bus.inst_valid && irdy_i && !rst_i && !redir_i) deliv_q.push_back(bus.inst_pc);
    if (bus.imem_req_valid && rreq_i) n_fire++;
    o_next = bus.pc_next;
    o_rv   = bus.imem_req_valid;
    @(posedge clk);
    #1;
    bus.pc_in = o_next;
    if (rsp) m = mem_q.pop_front();
    if (rst_i) begin
      mem_q.delete();
      buf_q.delete();
    end else if (redir_i) begin
      buf_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
    end else begin
      if (cons) void'(buf_q.pop_front());
      if (rsp && !m.stale) buf_q.push_back('{pc: m.addr, data: data_of(m.addr)});
    end
    if (fire) mem_q.push_back('{addr: pc_now, due: cyc + lat, stale: 1'b0});
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit irdy_i);
    logic [31:0] nx;
    bit          rv;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, irdy_i, nx, rv);
  endtask

  task automatic do_reset(input int n);
    logic [31:0] nx;
    bit          rv;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, nx, rv);
  endtask

  initial begin
    logic [31:0] nx;
    bit          rv;
    bit          found;
    rst = 1'b1;
    bus.pc_in = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.inst_ready = 1'b0;
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          1'b1, 32'h0000_0001, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h0000_0010, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,          1'b1, 32'h0000_0000, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,          1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0033, 32'h0000_0077, 1'b1, RESET_PC,       1'b0};
    @(negedge clk);

    // Single-cycle next-PC / request-valid vectors from an empty pipeline.
    for (int i = 0; i < 6; i++) begin
      do_reset(1);
      bus.pc_in = tbl[i].pc;
      step(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, 1'b1, nx, rv);
      chk($sformatf("tbl%0d_pc_next", i), nx, tbl[i].exp_next);
      chk($sformatf("tbl%0d_req_valid", i), rv, tbl[i].exp_rv);
    end

    // Steady stream from reset.
    do_reset(3);
    chk("t1_reset_pc", bus.pc_in, RESET_PC);
    lat = 1;
    deliv_q.delete();
    run(20, 1'b1);
    chk("t1_count_ok", deliv_q.size() >= 10, 1);
    chk("t1_first", deliv_q.size() > 0 ? deliv_q[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t1_seq", seq_bad(), 0);

    // Decode backpressure: only DEPTH reads may be issued.
    do_reset(1);
    n_fire = 0;
    run(10, 1'b0);
    chk("t2_fires", n_fire, DEPTH);
    chk("t2_req_valid", bus.imem_req_valid, 1'b0);
    chk("t2_pc_hold", bus.pc_next, bus.pc_in);
    deliv_q.delete();
    run(20, 1'b1);
    chk("t2_first", deliv_q.size() > 0 ? deliv_q[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t2_count_ok", deliv_q.size() >= 8, 1);
    chk("t2_seq", seq_bad(), 0);

    // Redirect with two reads in flight.
    do_reset(1);
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, nx, rv);
    end
    chk("t3_setup", mem_q.size(), 2);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, nx, rv);
    deliv_q.delete();
    run(25, 1'b1);
    chk("t3_first", deliv_q.size() > 0 ? deliv_q[0] : 32'hDEAD_BEEF, 32'h40);
    chk("t3_seq", seq_bad(), 0);

    // Redirect coinciding with a response and a consume.
    do_reset(1);
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && buf_q.size() > 0) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, nx, rv);
    end
    chk("t4_setup", found, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, nx, rv);
    chk("t4_inst_valid", bus.inst_valid, 1'b0);
    deliv_q.delete();
    run(15, 1'b1);
    chk("t4_first", deliv_q.size() > 0 ? deliv_q[0] : 32'hDEAD_BEEF, 32'h40);
    chk("t4_seq", seq_bad(), 0);

    // Random memory readiness, decode readiness and redirects with a 3-cycle memory.
    do_reset(1);
    lat = 3;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom();
      step(1'b0, $urandom_range(0, 99) < 3, tgt, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, nx, rv);
    end

    // Wrap-around stream, then reset mid-stream.
    lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, nx, rv);
    deliv_q.delete();
    run(15, 1'b1);
    chk("t6_wrap_first", deliv_q.size() > 0 ? deliv_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFE);
    chk("t6_wrap_len_ok", deliv_q.size() >= 4, 1);
    chk("t6_wrap_seq", seq_bad(), 0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, nx, rv);
    chk("t6_rst_pc_next", nx, RESET_PC);
    chk("t6_rst_inst_valid", bus.inst_valid, 1'b0);
    chk("t6_rst_pc_in", bus.pc_in, RESET_PC);
    deliv_q.delete();
    run(10, 1'b1);
    chk("t6_after_first", deliv_q.size() > 0 ? deliv_q[0] : 32'hDEAD_BEEF, RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
